// File: rtl/nb_agc_loop.sv
`default_nettype none
// ============================================================================
// Module      : nb_agc_loop
// Description : Closed-loop narrowband AGC placed after the DDC. Measures the
//               average envelope magnitude of the decimated I/Q stream over a
//               2^len sample window, compares it with a setpoint and runs a
//               first-order log-domain integrator whose exponent/mantissa
//               word feeds back to the DDC gain input.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               clkEn             - sample strobe (DDC syncOut)
//               iIn, qIn          - signed 18-bit I/Q samples
//               enable, hold      - loop enable, integrator freeze
//               setpoint          - unsigned target magnitude
//               log2Len           - window length exponent
//               loopShift         - error gain shift (0..11)
//               nbAgcGain         - {exponent[4:0], mantissa[15:0]}
//               gainValid         - one-cycle pulse on gain update
//               avgLevel          - last window average magnitude
//               overrun           - sticky, a window dump was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module nb_agc_loop #(
    parameter logic [25:0] RESET_GAIN  = 26'h0200000,
    parameter int          MAX_LOG2LEN = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkEn,
    input  logic [17:0] iIn,
    input  logic [17:0] qIn,
    input  logic        enable,
    input  logic        hold,
    input  logic [17:0] setpoint,
    input  logic [3:0]  log2Len,
    input  logic [3:0]  loopShift,
    output logic [20:0] nbAgcGain,
    output logic        gainValid,
    output logic [18:0] avgLevel,
    output logic        overrun
);

    localparam int          CNT_W     = MAX_LOG2LEN + 1;
    localparam logic [3:0]  c_MAX_LEN = 4'(MAX_LOG2LEN);
    localparam logic [3:0]  c_MAX_SHIFT = 4'd11;
    localparam logic [20:0] c_RESET_WORD = {RESET_GAIN[25:21], 1'b1, RESET_GAIN[20:6]};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_ERR   = 2'd2;
    localparam logic [1:0] c_UPD   = 2'd3;

    logic [1:0]        r_state;
    logic [30:0]       r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_len;
    logic [30:0]       r_dump;
    logic [3:0]        r_dump_len;
    logic [19:0]       r_err;
    logic [25:0]       r_gain;
    logic              r_upd_pending;
    logic [20:0]       r_gain_word;
    logic              r_gain_valid;
    logic [18:0]       r_avg;
    logic              r_overrun;

    // ------------------------------------------------------------------
    // Magnitude estimate: max + min/2. The only negative value with no
    // positive counterpart (-131072) saturates to 131071.
    // ------------------------------------------------------------------
    logic [17:0] w_abs_i18;
    logic [17:0] w_abs_q18;
    logic [16:0] w_abs_i;
    logic [16:0] w_abs_q;
    logic [16:0] w_max;
    logic [16:0] w_min;
    logic [18:0] w_mag;

    always_comb begin
        w_abs_i18 = iIn[17] ? (18'd0 - iIn) : iIn;
        w_abs_q18 = qIn[17] ? (18'd0 - qIn) : qIn;
        w_abs_i   = w_abs_i18[17] ? 17'h1FFFF : w_abs_i18[16:0];
        w_abs_q   = w_abs_q18[17] ? 17'h1FFFF : w_abs_q18[16:0];
        if (w_abs_i >= w_abs_q) begin
            w_max = w_abs_i;
            w_min = w_abs_q;
        end else begin
            w_max = w_abs_q;
            w_min = w_abs_i;
        end
        w_mag = {2'b00, w_max} + {2'b00, (w_min >> 1)};
    end

    // ------------------------------------------------------------------
    // Window control
    // ------------------------------------------------------------------
    logic [3:0]       w_len_clamped;
    logic [CNT_W-1:0] w_one;
    logic [CNT_W-1:0] w_win_max;
    logic             w_accept;
    logic             w_dump;
    logic [30:0]      w_acc_sum;

    assign w_len_clamped = (log2Len > c_MAX_LEN) ? c_MAX_LEN : log2Len;
    assign w_one         = CNT_W'(1);
    assign w_win_max     = (w_one << r_len) - w_one;
    // Samples are only taken once the loop has left IDLE; the next window
    // keeps accumulating while ERR/UPD run for the previous one.
    assign w_accept      = clkEn & enable & (r_state != c_IDLE);
    assign w_dump        = w_accept & (r_cnt == w_win_max);
    assign w_acc_sum     = r_acc + {12'd0, w_mag};

    // ------------------------------------------------------------------
    // Error and integrator arithmetic
    // ------------------------------------------------------------------
    logic [18:0]        w_avg;
    logic [19:0]        w_err;
    logic [3:0]         w_shift;
    logic signed [33:0] w_err_ext;
    logic signed [33:0] w_step;
    logic signed [33:0] w_gain_sum;
    logic [25:0]        w_gain_sat;

    assign w_avg      = 19'(r_dump >> r_dump_len);
    assign w_err      = {2'b00, setpoint} - {1'b0, w_avg};
    assign w_shift    = (loopShift > c_MAX_SHIFT) ? c_MAX_SHIFT : loopShift;
    assign w_err_ext  = {{14{r_err[19]}}, r_err};
    assign w_step     = w_err_ext <<< w_shift;
    assign w_gain_sum = $signed({8'd0, r_gain}) + w_step;

    // Saturate rather than wrap: negative clamps to 0, anything above
    // 26 bits clamps to full scale.
    always_comb begin
        if (w_gain_sum[33]) begin
            w_gain_sat = 26'd0;
        end else if (|w_gain_sum[32:26]) begin
            w_gain_sat = 26'h3FFFFFF;
        end else begin
            w_gain_sat = w_gain_sum[25:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_len         <= '0;
            r_dump        <= '0;
            r_dump_len    <= '0;
            r_err         <= '0;
            r_gain        <= RESET_GAIN;
            r_upd_pending <= 1'b0;
            r_gain_word   <= c_RESET_WORD;
            r_gain_valid  <= 1'b0;
            r_avg         <= '0;
            r_overrun     <= 1'b0;
        end else if (!enable) begin
            // Abandon any pending update; gain is held where it is.
            r_state       <= c_IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_upd_pending <= 1'b0;
            r_gain_valid  <= 1'b0;
        end else begin
            r_gain_valid  <= 1'b0;
            r_upd_pending <= 1'b0;

            if (w_accept) begin
                if (w_dump) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_len <= w_len_clamped;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            case (r_state)
                c_IDLE: begin
                    r_state <= c_ACCUM;
                    r_len   <= w_len_clamped;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                c_ACCUM: begin
                    if (w_dump) begin
                        r_dump     <= w_acc_sum;
                        r_dump_len <= r_len;
                        r_state    <= c_ERR;
                    end
                end
                c_ERR: begin
                    r_avg   <= w_avg;
                    r_err   <= w_err;
                    r_state <= c_UPD;
                    if (w_dump) begin
                        r_overrun <= 1'b1;
                    end
                end
                c_UPD: begin
                    if (!hold) begin
                        r_gain <= w_gain_sat;
                    end
                    r_upd_pending <= ~hold;
                    r_state       <= c_ACCUM;
                    if (w_dump) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (r_upd_pending) begin
                r_gain_word  <= {r_gain[25:21], 1'b1, r_gain[20:6]};
                r_gain_valid <= 1'b1;
            end
        end
    end

    assign nbAgcGain = r_gain_word;
    assign gainValid = r_gain_valid;
    assign avgLevel  = r_avg;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nb_agc_loop.sv
`default_nettype none
// ============================================================================
// Module      : tb_nb_agc_loop
// Description : Directed self-checking bench for nb_agc_loop. Each scenario
//               task drives stimulus and compares against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nb_agc_loop;

    localparam logic [25:0] RESET_GAIN = 26'h0200000;

    logic        clk;
    logic        reset;
    logic        clkEn;
    logic signed [17:0] iIn;
    logic signed [17:0] qIn;
    logic        enable;
    logic        hold;
    logic [17:0] setpoint;
    logic [3:0]  log2Len;
    logic [3:0]  loopShift;
    logic [20:0] nbAgcGain;
    logic        gainValid;
    logic [18:0] avgLevel;
    logic        overrun;

    int total;
    int bad;
    int gv_count;

    logic [20:0] reset_word;

    nb_agc_loop #(
        .RESET_GAIN  (RESET_GAIN),
        .MAX_LOG2LEN (12)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clkEn     (clkEn),
        .iIn       (iIn),
        .qIn       (qIn),
        .enable    (enable),
        .hold      (hold),
        .setpoint  (setpoint),
        .log2Len   (log2Len),
        .loopShift (loopShift),
        .nbAgcGain (nbAgcGain),
        .gainValid (gainValid),
        .avgLevel  (avgLevel),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count gain update pulses, sampled mid-cycle.
    initial gv_count = 0;
    always @(negedge clk) begin
        if (gainValid === 1'b1) gv_count = gv_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        clkEn  = 1'b0;
        hold   = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // gap-1 idle cycles then one strobe; returns 1ns after the strobe edge.
    task automatic send(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            repeat (gap - 1) tick();
            clkEn = 1'b1;
            tick();
            clkEn = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clkEn = 1'b0; hold = 1'b0;
        iIn = '0; qIn = '0; setpoint = '0; log2Len = '0; loopShift = '0;
        repeat (3) tick();
        total++; if (nbAgcGain !== reset_word) begin $display("FAIL reset_gain: got %06h want %06h", nbAgcGain, reset_word); bad++; end
        total++; if (gainValid !== 1'b0) begin $display("FAIL reset_valid: got %0b want 0", gainValid); bad++; end
        total++; if (avgLevel !== 19'd0) begin $display("FAIL reset_avg: got %0d want 0", avgLevel); bad++; end
        total++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun: got %0b want 0", overrun); bad++; end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_step();
        do_reset();
        iIn = 18'sd65536; qIn = 18'sd0; setpoint = 18'd32768; log2Len = 4'd4; loopShift = 4'd0;
        enable = 1'b1;
        tick();
        send(16, 4);
        tick();
        total++; if (avgLevel !== 19'd65536) begin $display("FAIL step_avg: got %0d want 65536", avgLevel); bad++; end
        total++; if (gainValid !== 1'b0) begin $display("FAIL step_valid_t1: got %0b want 0", gainValid); bad++; end
        tick();
        total++; if (gainValid !== 1'b0) begin $display("FAIL step_valid_t2: got %0b want 0", gainValid); bad++; end
        tick();
        total++; if (gainValid !== 1'b1) begin $display("FAIL step_valid_t3: got %0b want 1", gainValid); bad++; end
        total++; if (nbAgcGain !== 21'h00FE00) begin $display("FAIL step_gain: got %06h want 00fe00", nbAgcGain); bad++; end
        tick();
        total++; if (gainValid !== 1'b0) begin $display("FAIL step_valid_t4: got %0b want 0", gainValid); bad++; end
    endtask

    task automatic test_mag_sat();
        do_reset();
        iIn = -18'sd131072; qIn = -18'sd131072; setpoint = 18'd0; log2Len = 4'd0; loopShift = 4'd0;
        enable = 1'b1;
        tick();
        send(1, 2);
        tick();
        total++; if (avgLevel !== 19'd196606) begin $display("FAIL mag_sat_avg: got %0d want 196606", avgLevel); bad++; end
        repeat (3) tick();
        // gainInt = 0x200000 - 196606 = 0x1D0002
        total++; if (nbAgcGain !== 21'h00F400) begin $display("FAIL mag_sat_gain: got %06h want 00f400", nbAgcGain); bad++; end
    endtask

    task automatic test_upper_clamp();
        int base;
        do_reset();
        base = gv_count;
        iIn = '0; qIn = '0; setpoint = 18'd131071; log2Len = 4'd2; loopShift = 4'd11;
        enable = 1'b1;
        tick();
        for (int w = 0; w < 3; w++) begin
            send(4, 2);
            repeat (4) tick();
            total++; if (nbAgcGain !== 21'h1FFFFF) begin $display("FAIL upper_clamp_w%0d: got %06h want 1fffff", w, nbAgcGain); bad++; end
        end
        total++; if (gv_count - base !== 3) begin $display("FAIL upper_clamp_pulses: got %0d want 3", gv_count - base); bad++; end
    endtask

    task automatic test_lower_clamp();
        do_reset();
        iIn = 18'sd131071; qIn = '0; setpoint = 18'd0; log2Len = 4'd0; loopShift = 4'd11;
        enable = 1'b1;
        tick();
        for (int w = 0; w < 2; w++) begin
            send(1, 4);
            repeat (4) tick();
            total++; if (nbAgcGain !== 21'h008000) begin $display("FAIL lower_clamp_w%0d: got %06h want 008000", w, nbAgcGain); bad++; end
        end
        // Reset mid-operation returns everything to reset values.
        reset = 1'b1;
        tick();
        total++; if (nbAgcGain !== reset_word) begin $display("FAIL midreset_gain: got %06h want %06h", nbAgcGain, reset_word); bad++; end
        total++; if (avgLevel !== 19'd0) begin $display("FAIL midreset_avg: got %0d want 0", avgLevel); bad++; end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        int base;
        do_reset();
        base = gv_count;
        hold = 1'b1; setpoint = 18'd0; log2Len = 4'd1; loopShift = 4'd0;
        iIn = 18'sd1000; qIn = 18'sd600;
        enable = 1'b1;
        tick();
        send(2, 2);
        repeat (4) tick();
        total++; if (avgLevel !== 19'd1300) begin $display("FAIL hold_avg1: got %0d want 1300", avgLevel); bad++; end
        iIn = 18'sd0; qIn = -18'sd2000;
        send(2, 2);
        repeat (4) tick();
        total++; if (avgLevel !== 19'd2000) begin $display("FAIL hold_avg2: got %0d want 2000", avgLevel); bad++; end
        total++; if (nbAgcGain !== reset_word) begin $display("FAIL hold_gain: got %06h want %06h", nbAgcGain, reset_word); bad++; end
        total++; if (gv_count - base !== 0) begin $display("FAIL hold_pulses: got %0d want 0", gv_count - base); bad++; end
        // Release hold with zero error: gain must still equal the preset.
        hold = 1'b0; setpoint = 18'd2000;
        send(2, 2);
        repeat (4) tick();
        total++; if (gv_count - base !== 1) begin $display("FAIL unhold_pulses: got %0d want 1", gv_count - base); bad++; end
        total++; if (nbAgcGain !== reset_word) begin $display("FAIL unhold_gain: got %06h want %06h", nbAgcGain, reset_word); bad++; end
    endtask

    task automatic test_overrun();
        do_reset();
        iIn = 18'sd100; qIn = '0; setpoint = 18'd100; log2Len = 4'd0; loopShift = 4'd0;
        enable = 1'b1;
        tick();
        clkEn = 1'b1;
        tick();
        total++; if (overrun !== 1'b0) begin $display("FAIL overrun_first: got %0b want 0", overrun); bad++; end
        tick();
        total++; if (overrun !== 1'b1) begin $display("FAIL overrun_second: got %0b want 1", overrun); bad++; end
        repeat (5) tick();
        clkEn = 1'b0;
        tick();
        total++; if (overrun !== 1'b1) begin $display("FAIL overrun_sticky: got %0b want 1", overrun); bad++; end
    endtask

    task automatic test_enable_drop();
        int base;
        do_reset();
        base = gv_count;
        iIn = 18'sd10000; qIn = '0; setpoint = 18'd24000; log2Len = 4'd2; loopShift = 4'd2;
        enable = 1'b1;
        tick();
        send(2, 2);
        enable = 1'b0;
        repeat (3) tick();
        total++; if (nbAgcGain !== reset_word) begin $display("FAIL en_drop_gain: got %06h want %06h", nbAgcGain, reset_word); bad++; end
        enable = 1'b1;
        tick();
        iIn = 18'sd20000;
        send(3, 2);
        repeat (4) tick();
        total++; if (gv_count - base !== 0) begin $display("FAIL en_restart_early: got %0d want 0", gv_count - base); bad++; end
        send(1, 2);
        repeat (4) tick();
        total++; if (gv_count - base !== 1) begin $display("FAIL en_restart_pulses: got %0d want 1", gv_count - base); bad++; end
        total++; if (avgLevel !== 19'd20000) begin $display("FAIL en_restart_avg: got %0d want 20000", avgLevel); bad++; end
        // err = 4000, <<2 = 16000; gainInt = 0x203E80
        total++; if (nbAgcGain !== 21'h0180FA) begin $display("FAIL en_restart_gain: got %06h want 0180fa", nbAgcGain); bad++; end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_word = {RESET_GAIN[25:21], 1'b1, RESET_GAIN[20:6]};
        test_reset();
        test_step();
        test_mag_sat();
        test_upper_clamp();
        test_lower_clamp();
        test_hold();
        test_overrun();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
